// File: rtl/gpu_vga_pkg.sv
// gpu_vga_pkg
//   Shared definitions for the GPU / VGA framebuffer blocks.
//   Holds the default display geometry, the widths derived from it and the
//   fetch state type used by the framebuffer port scheduler.
package gpu_vga_pkg;

  // Default visible geometry and pixel width.
  localparam int DEF_DISPLAY_W = 640;
  localparam int DEF_DISPLAY_H = 480;
  localparam int DEF_DATA_W    = 8;

  // Widths derived from the default geometry.
  localparam int DEF_PIX_W  = $clog2(DEF_DISPLAY_W * DEF_DISPLAY_H);
  localparam int DEF_ADDR_W = DEF_PIX_W + 1;
  localparam int DEF_LB_W   = $clog2(DEF_DISPLAY_W) + 1;
  localparam int DEF_Y_W    = $clog2(DEF_DISPLAY_H);

  // Line prefetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/line_fetch_cnt.sv
// line_fetch_cnt
//   Pixel counter for one line prefetch plus the delayed line-buffer strobe.
//   The read for x=0 is issued in the start cycle itself, so the counter
//   only has to hold x=1..DISPLAY_W-1 while the top keeps run asserted.
//   Every issued read produces a line-buffer write one cycle later, which
//   lines up with the 1-cycle RAM read latency.
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   start      first read of a new line is issued this cycle
//   run        top is in FETCH, keep issuing reads from the counter
//   bank       line-buffer bank of the line being started (target LSB)
//   rd_valid   a read is issued this cycle
//   rd_x       pixel index of the read issued this cycle
//   last       the read issued this cycle is the final one of the line
//   lb_we      line-buffer write strobe (previous cycle's read)
//   lb_addr    line-buffer address {bank, x} for lb_we
module line_fetch_cnt #(
  parameter  int DISPLAY_W = 640,
  localparam int X_W       = $clog2(DISPLAY_W),
  localparam int LB_W      = X_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  input  logic            bank,
  output logic            rd_valid,
  output logic [X_W-1:0]  rd_x,
  output logic            last,
  output logic            lb_we,
  output logic [LB_W-1:0] lb_addr
);

  logic [X_W-1:0]  x_q;
  logic            bank_q;
  logic            lb_we_q;
  logic [LB_W-1:0] lb_addr_q;
  logic            rd_bank;

  assign rd_valid = start | run;
  assign rd_x     = start ? '0 : x_q;
  assign rd_bank  = start ? bank : bank_q;
  assign last     = run && (x_q == X_W'(DISPLAY_W - 1));

  // Advance the pixel index on every issued read and remember where the
  // read lands in the line buffer so the strobe follows one cycle later.
  // A reset clears the pending strobe, which aborts an in-flight line.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      bank_q    <= 1'b0;
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
    end else begin
      if (rd_valid) begin
        x_q       <= rd_x + 1'b1;
        lb_addr_q <= {rd_bank, rd_x};
      end
      if (start) begin
        bank_q <= bank;
      end
      lb_we_q <= rd_valid;
    end
  end

  assign lb_we   = lb_we_q;
  assign lb_addr = lb_addr_q;

endmodule

// File: rtl/fb_port_sched.sv
// fb_port_sched
//   Arbitrates the single framebuffer RAM port between display line
//   prefetch and GPU pixel writes. A fetch of visible line y+1 (or line 0
//   at frame wrap) streams into a ping-pong line buffer while line y is
//   shown; GPU writes to the back buffer use the cycles the fetch leaves
//   free. Front/back buffer selection swaps only at a frame boundary.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   h_disp_done_i   pulse: visible part of the current line ended
//   v_display_i     vertical counter is in the visible region
//   v_pos_i         current visible line index
//   frame_done_i    pulse: frame wrapped to line 0
//   wr_req_i/addr/data  GPU write request, pixel index, pixel value
//   wr_gnt_o        GPU write accepted this cycle
//   swap_req_i      request a front/back swap at the next frame boundary
//   swap_done_o     pulse one cycle after the swap was applied
//   front_sel_o     buffer currently displayed
//   mem_*           RAM port (read data arrives one cycle after a read)
//   lb_*            line-buffer write port {bank, x}
//   overrun_o       sticky: a fetch trigger hit a fetch still running
module fb_port_sched
  import gpu_vga_pkg::*;
#(
  parameter  int DISPLAY_W = DEF_DISPLAY_W,
  parameter  int DISPLAY_H = DEF_DISPLAY_H,
  parameter  int DATA_W    = DEF_DATA_W,
  localparam int PIX_W     = $clog2(DISPLAY_W * DISPLAY_H),
  localparam int ADDR_W    = PIX_W + 1,
  localparam int LB_W      = $clog2(DISPLAY_W) + 1,
  localparam int Y_W       = $clog2(DISPLAY_H),
  localparam int X_W       = LB_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_disp_done_i,
  input  logic              v_display_i,
  input  logic [Y_W-1:0]    v_pos_i,
  input  logic              frame_done_i,
  input  logic              wr_req_i,
  input  logic [PIX_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              swap_req_i,
  output logic              swap_done_o,
  output logic              front_sel_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              lb_we_o,
  output logic [LB_W-1:0]   lb_addr_o,
  output logic [DATA_W-1:0] lb_data_o,
  output logic              overrun_o
);

  fetch_state_t   state_q, state_d;
  logic [Y_W-1:0] line_q;
  logic [Y_W-1:0] target;
  logic [Y_W-1:0] rd_line;
  logic           fetch_buf_q;
  logic           front_sel_q;
  logic           swap_pend_q;
  logic           swap_done_q;
  logic           overrun_q;
  logic           line_trig;
  logic           trigger;
  logic           in_fetch;
  logic           start;
  logic           run;
  logic           swap_now;
  logic           front_sel_nxt;
  logic           rd_buf;
  logic           rd_valid;
  logic           last;
  logic [X_W-1:0] rd_x;
  logic [PIX_W-1:0] rd_pix;

  // Fetch triggers. The last visible line has no successor, so its
  // end-of-line pulse is ignored; frame wrap always refetches line 0.
  assign line_trig = h_disp_done_i && v_display_i && (v_pos_i < Y_W'(DISPLAY_H - 1));
  assign trigger   = !rst && (frame_done_i || line_trig);
  assign target    = frame_done_i ? '0 : v_pos_i + 1'b1;
  assign in_fetch  = (state_q == FETCH);
  assign start     = trigger && !in_fetch;
  assign run       = !rst && in_fetch;

  // The swap decided this cycle must already steer the line-0 fetch that
  // the same frame_done_i starts, hence the next-value select.
  assign swap_now      = !rst && frame_done_i && (swap_pend_q || swap_req_i);
  assign front_sel_nxt = front_sel_q ^ swap_now;

  // A running fetch keeps the line and buffer it was started with, even if
  // a swap lands in the middle of it.
  assign rd_line = start ? target : line_q;
  assign rd_buf  = start ? front_sel_nxt : fetch_buf_q;
  assign rd_pix  = PIX_W'(rd_line) * PIX_W'(DISPLAY_W) + PIX_W'(rd_x);

  // Fetch owns the port outright; writes only fit where no read is issued.
  assign wr_gnt_o = !rst && wr_req_i && !trigger && !in_fetch;

  line_fetch_cnt #(
    .DISPLAY_W (DISPLAY_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run      (run),
    .bank     (target[0]),
    .rd_valid (rd_valid),
    .rd_x     (rd_x),
    .last     (last),
    .lb_we    (lb_we_o),
    .lb_addr  (lb_addr_o)
  );

  // RAM port mux: the current fetch read, otherwise a granted GPU write to
  // the back buffer, otherwise the port stays quiet.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rd_valid) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {rd_buf, rd_pix};
    end else if (wr_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = {~front_sel_q, wr_addr_i};
      mem_wdata_o = wr_data_i;
    end
  end

  // Sequencer: the start cycle issues x=0 from IDLE or DRAIN, FETCH covers
  // the remaining reads, DRAIN is the cycle of the final line-buffer write
  // and may already start the next line.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (last) state_d = DRAIN;
      DRAIN:   state_d = start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, fetch context, buffer selection, swap handshake and the sticky
  // overrun flag. Repeated swap requests simply keep the pending bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      fetch_buf_q <= 1'b0;
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        line_q      <= target;
        fetch_buf_q <= front_sel_nxt;
      end
      front_sel_q <= front_sel_nxt;
      swap_done_q <= swap_now;
      swap_pend_q <= swap_now ? 1'b0 : (swap_pend_q | swap_req_i);
      if (trigger && in_fetch) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign front_sel_o = front_sel_q;
  assign swap_done_o = swap_done_q;
  assign overrun_o   = overrun_q;
  assign lb_data_o   = mem_rdata_i;

endmodule

// File: tb/tb_fb_port_sched.sv
// tb_fb_port_sched
//   Directed scenarios followed by a randomized phase. A small RAM model
//   answers the DUT's reads, and a timeline model of fetches (start cycle,
//   line, buffer) predicts every port transaction from the scheduling rules.
module tb_fb_port_sched;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int DATA_W = 8;
  localparam int PIX_W  = $clog2(W * H);
  localparam int ADDR_W = PIX_W + 1;
  localparam int LB_W   = $clog2(W) + 1;
  localparam int Y_W    = $clog2(H);

  logic              clk = 1'b0;
  logic              rst;
  logic              h_disp_done_i;
  logic              v_display_i;
  logic [Y_W-1:0]    v_pos_i;
  logic              frame_done_i;
  logic              wr_req_i;
  logic [PIX_W-1:0]  wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_gnt_o;
  logic              swap_req_i;
  logic              swap_done_o;
  logic              front_sel_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              lb_we_o;
  logic [LB_W-1:0]   lb_addr_o;
  logic [DATA_W-1:0] lb_data_o;
  logic              overrun_o;

  always #5 clk = ~clk;

  fb_port_sched #(
    .DISPLAY_W (W),
    .DISPLAY_H (H),
    .DATA_W    (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .h_disp_done_i (h_disp_done_i),
    .v_display_i   (v_display_i),
    .v_pos_i       (v_pos_i),
    .frame_done_i  (frame_done_i),
    .wr_req_i      (wr_req_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_gnt_o      (wr_gnt_o),
    .swap_req_i    (swap_req_i),
    .swap_done_o   (swap_done_o),
    .front_sel_o   (front_sel_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .lb_we_o       (lb_we_o),
    .lb_addr_o     (lb_addr_o),
    .lb_data_o     (lb_data_o),
    .overrun_o     (overrun_o)
  );

  int compared   = 0;
  int mismatched = 0;

  // Framebuffer contents seen by the DUT.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdataNext;
  bit                rdPending;

  // Reference model: fetch timeline and registered-output predictions.
  int  mCyc = 0;
  int  fStart, fLine, fBuf;
  bit  fActive = 0;
  bit  mFront = 0, mPend = 0, mOvr = 0, mSwapDone = 0, mValid = 0;
  bit  prevRd = 0;
  int  prevLb = 0;
  logic [DATA_W-1:0] prevData = '0;

  // Predictions for the cycle being checked.
  bit  eStart, eOvr, eSwap, eRd, eGnt, eNewFront;
  int  eTgt, eAddr, eRdLine, eRdX;
  logic [DATA_W-1:0] eRdData;

  task automatic checkValue(input string tag, input logic [31:0] obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, mCyc, obs, exp);
    end
  endtask

  // Predict this cycle's port activity from the inputs and fetch timeline.
  task automatic computeExpect();
    int age;
    bit busy, trig;
    trig = !rst && (frame_done_i ||
                    (h_disp_done_i && v_display_i && int'(v_pos_i) < H - 1));
    eTgt      = frame_done_i ? 0 : int'(v_pos_i) + 1;
    age       = mCyc - fStart;
    busy      = fActive && age >= 1 && age <= W - 1;
    eStart    = trig && !busy;
    eOvr      = trig && busy;
    eSwap     = !rst && frame_done_i && (mPend || swap_req_i);
    eNewFront = mFront ^ eSwap;
    eGnt      = !rst && wr_req_i && !trig && !busy;
    eRd = 0; eAddr = 0; eRdLine = 0; eRdX = 0;
    if (eStart) begin
      eRd = 1; eRdLine = eTgt; eRdX = 0;
      eAddr = int'(eNewFront) * W * H + eTgt * W;
    end else if (busy && !rst) begin
      eRd = 1; eRdLine = fLine; eRdX = age;
      eAddr = fBuf * W * H + fLine * W + age;
    end
  endtask

  task automatic checkOutput();
    checkValue("wr_gnt", 32'(wr_gnt_o), int'(eGnt));
    checkValue("mem_en", 32'(mem_en_o), int'(eRd || eGnt));
    checkValue("mem_we", 32'(mem_we_o), int'(eGnt));
    if (eRd) begin
      checkValue("rd_addr", 32'(mem_addr_o), eAddr);
    end else if (eGnt) begin
      checkValue("wr_addr", 32'(mem_addr_o), int'(!mFront) * W * H + int'(wr_addr_i));
      checkValue("wr_data", 32'(mem_wdata_o), int'(wr_data_i));
    end
    checkValue("lb_we", 32'(lb_we_o), int'(prevRd));
    if (prevRd) begin
      checkValue("lb_addr", 32'(lb_addr_o), prevLb);
      checkValue("lb_data", 32'(lb_data_o), int'(prevData));
    end
    checkValue("front_sel", 32'(front_sel_o), int'(mFront));
    checkValue("swap_done", 32'(swap_done_o), int'(mSwapDone));
    checkValue("overrun", 32'(overrun_o), int'(mOvr));
  endtask

  // RAM behaviour driven by what the DUT actually put on the port.
  task automatic serviceRam();
    eRdData = eRd ? ram[ADDR_W'(eAddr)] : '0;
    rdPending = 0;
    if (mem_en_o === 1'b1 && mem_we_o === 1'b0) begin
      rdPending = 1;
      rdataNext = ram[mem_addr_o];
    end
    if (mem_en_o === 1'b1 && mem_we_o === 1'b1) begin
      ram[mem_addr_o] = mem_wdata_o;
    end
  endtask

  task automatic modelAdvance();
    if (rst) begin
      mFront = 0; mPend = 0; mOvr = 0; mSwapDone = 0;
      fActive = 0; prevRd = 0; mValid = 1;
    end else begin
      if (eStart) begin
        fActive = 1; fStart = mCyc; fLine = eTgt; fBuf = int'(eNewFront);
      end
      if (eOvr) mOvr = 1;
      mFront    = eNewFront;
      mSwapDone = eSwap;
      mPend     = eSwap ? 1'b0 : (mPend || swap_req_i);
      prevRd    = eRd;
      prevLb    = (eRdLine % 2) * W + eRdX;
      prevData  = eRdData;
    end
    mCyc++;
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model
  // at the rising edge and return the RAM read data just after it.
  task automatic applyStimulus(input bit r, input bit fd, input bit hd, input bit vd,
                               input int vpos, input bit wreq, input int waddr,
                               input int wdata, input bit swp);
    rst           = r;
    frame_done_i  = fd;
    h_disp_done_i = hd;
    v_display_i   = vd;
    v_pos_i       = Y_W'(vpos);
    wr_req_i      = wreq;
    wr_addr_i     = PIX_W'(waddr);
    wr_data_i     = DATA_W'(wdata);
    swap_req_i    = swp;
    @(negedge clk);
    computeExpect();
    if (mValid) checkOutput();
    serviceRam();
    @(posedge clk);
    modelAdvance();
    #1;
    mem_rdata_i = rdPending ? rdataNext : DATA_W'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit r, fd, hd, vd, wq, sw;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom_range(0, 255));
    mem_rdata_i = '0;
    $display("[TB] fb_port_sched bench start");

    // Reset held two cycles, then a frame wrap fetches line 0.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(10);

    // Line 1 done fetches line 2; the last line does not trigger.
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 0);
    idle(10);
    applyStimulus(0, 0, 1, 1, 3, 0, 0, 0, 0);
    idle(2);

    // GPU write held against a fetch that starts the same cycle.
    applyStimulus(0, 0, 1, 1, 0, 1, 5, 8'hAA, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 0, 1, 5, 8'hAA, 0);
    idle(2);

    // Swap request, applied at the next frame wrap; then a back-buffer write.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(9);
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 8'h5C, 0);
    idle(2);

    // Second trigger three cycles into a fetch, then reset clears overrun.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(8);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset in the middle of a fetch.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      fd = ($urandom_range(0, 39) == 0);
      hd = ($urandom_range(0, 9) == 0);
      vd = ($urandom_range(0, 3) != 0);
      wq = ($urandom_range(0, 1) == 1);
      sw = ($urandom_range(0, 29) == 0);
      applyStimulus(r, fd, hd, vd, int'($urandom_range(0, H - 1)), wq,
                    int'($urandom_range(0, W * H - 1)), int'($urandom_range(0, 255)), sw);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
